// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the ALU share controller: op codes, FSM states, lane geometry.
package alu_share_ctrl_pkg;

  localparam int LANE_W    = 32;
  localparam int NUM_LANES = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_e;

  // Multiply and divide need the long settle window.
  function automatic logic is_slow_op(input logic [2:0] sel);
    return (sel == OP_MUL) || (sel == OP_DIV);
  endfunction

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic id);
    return NUM_LANES'(1) << id;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the lane that did not win last gets the grant.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) grant_o = last_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters, one op in flight at a time.
// Optional ALU_DIV0_TRAP_EN: divide by zero is answered directly with an error flag.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int FAST_WAIT = 1,
  parameter int SLOW_WAIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_LANES-1:0]          req_valid,
  output logic [NUM_LANES-1:0]          req_ready,
  input  logic [NUM_LANES*LANE_W-1:0]   req_op1,
  input  logic [NUM_LANES*LANE_W-1:0]   req_op2,
  input  logic [NUM_LANES*3-1:0]        req_sel,
  output logic [NUM_LANES-1:0]          rsp_valid,
  input  logic [NUM_LANES-1:0]          rsp_ready,
  output logic [LANE_W-1:0]             rsp_res,
  output logic                          rsp_zero,
  output logic [LANE_W-1:0]             alu_op1,
  output logic [LANE_W-1:0]             alu_op2,
  output logic [2:0]                    alu_sel,
  input  logic [LANE_W-1:0]             alu_res,
  input  logic                          alu_nz
`ifdef ALU_DIV0_TRAP_EN
  ,
  output logic                          rsp_err
`endif
);

  localparam int MAX_WAIT = (SLOW_WAIT > FAST_WAIT) ? SLOW_WAIT : FAST_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  state_e                 state_q;
  logic                   rr_q;
  logic                   id_q;
  logic [CW-1:0]          cnt_q;
  logic [NUM_LANES-1:0]   rsp_valid_q;
  logic [LANE_W-1:0]      rsp_res_q;
  logic                   rsp_zero_q;
  logic [LANE_W-1:0]      alu_op1_q;
  logic [LANE_W-1:0]      alu_op2_q;
  logic [2:0]             alu_sel_q;

  logic [NUM_LANES-1:0]   gnt;
  logic                   gnt_id;
  logic                   hs;
  logic [LANE_W-1:0]      g_op1;
  logic [LANE_W-1:0]      g_op2;
  logic [2:0]             g_sel;
  logic [CW-1:0]          g_wait;
  logic                   unused_nz;

  assign unused_nz = alu_nz;

  rr_arb2 u_arb (
    .valid_i (req_valid),
    .last_i  (rr_q),
    .grant_o (gnt)
  );

  // Grant is only offered while idle and out of reset.
  assign req_ready = (state_q == ST_IDLE && rst_n) ? gnt : '0;
  assign hs        = |(req_valid & req_ready);
  assign gnt_id    = gnt[1];
  assign g_op1     = gnt_id ? req_op1[2*LANE_W-1:LANE_W] : req_op1[LANE_W-1:0];
  assign g_op2     = gnt_id ? req_op2[2*LANE_W-1:LANE_W] : req_op2[LANE_W-1:0];
  assign g_sel     = gnt_id ? req_sel[5:3] : req_sel[2:0];
  assign g_wait    = is_slow_op(g_sel) ? CW'(SLOW_WAIT) : CW'(FAST_WAIT);

`ifdef ALU_DIV0_TRAP_EN
  logic rsp_err_q;
  logic g_trap;
  assign g_trap  = (g_sel == OP_DIV) && (g_op2 == '0);
  assign rsp_err = rsp_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= 1'b1;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_res_q   <= '0;
      rsp_zero_q  <= 1'b0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_sel_q   <= '0;
`ifdef ALU_DIV0_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            id_q <= gnt_id;
            rr_q <= gnt_id;
`ifdef ALU_DIV0_TRAP_EN
            if (g_trap) begin
              rsp_res_q   <= '1;
              rsp_zero_q  <= 1'b0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= lane_onehot(gnt_id);
              state_q     <= ST_RESP;
            end else
`endif
            begin
              alu_op1_q <= g_op1;
              alu_op2_q <= g_op2;
              alu_sel_q <= g_sel;
              cnt_q     <= g_wait;
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            rsp_res_q   <= alu_res;
            rsp_zero_q  <= (alu_res == '0);
`ifdef ALU_DIV0_TRAP_EN
            rsp_err_q   <= 1'b0;
`endif
            rsp_valid_q <= lane_onehot(id_q);
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Only the owning lane's ready completes the response.
          if (rsp_ready[id_q]) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;
  assign alu_sel   = alu_sel_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU on the alu_* bus.
module tb_alu_share_ctrl;

  localparam int FAST = 1;
  localparam int SLOW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic [5:0]  req_sel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_res;
  logic        rsp_zero;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_sel;
  logic [31:0] alu_res;
  logic        alu_nz;
`ifdef ALU_DIV0_TRAP_EN
  logic        rsp_err;
`endif

  typedef struct {
    int          lane;
    logic [31:0] res;
    logic        zero;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   in_rsp = 1'b0;
  int   tb_last = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return a * b;
      3'b100:  return (b == 0) ? 32'h0 : a / b;
      3'b101:  return a & b;
      3'b110:  return a << b[4:0];
      default: return a | b;
    endcase
  endfunction

  assign alu_res = alu_f(alu_sel, alu_op1, alu_op2);
  assign alu_nz  = |alu_res;

  alu_share_ctrl #(.FAST_WAIT(FAST), .SLOW_WAIT(SLOW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_res   (rsp_res),
    .rsp_zero  (rsp_zero),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_sel   (alu_sel),
    .alu_res   (alu_res),
    .alu_nz    (alu_nz)
`ifdef ALU_DIV0_TRAP_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  // Response monitor: pop the expectation on the first cycle of each response.
  always @(negedge clk) begin
    if (rst_n && rsp_valid != 2'b00) begin
      if (!in_rsp) begin
        in_rsp = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b res=%h, want no response", rsp_valid, rsp_res);
        end else begin
          exp_t e;
          logic [1:0] ev;
          logic got_err;
          e = sb.pop_front();
          ev = 2'b01 << e.lane;
`ifdef ALU_DIV0_TRAP_EN
          got_err = rsp_err;
`else
          got_err = 1'b0;
`endif
          if (rsp_valid !== ev || rsp_res !== e.res || rsp_zero !== e.zero ||
              got_err !== e.err || (cyc - e.acc) != e.lat) begin
            errors++;
            $display("FAIL rsp_check: got valid=%b res=%h zero=%b err=%b lat=%0d, want valid=%b res=%h zero=%b err=%b lat=%0d",
                     rsp_valid, rsp_res, rsp_zero, got_err, cyc - e.acc, ev, e.res, e.zero, e.err, e.lat);
          end
        end
      end
      if (|(rsp_valid & rsp_ready)) in_rsp = 1'b0;
    end
  end

  task automatic set_lane(input int lane, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    req_op1[lane*32 +: 32] = a;
    req_op2[lane*32 +: 32] = b;
    req_sel[lane*3 +: 3]   = s;
  endtask

  task automatic push(input int lane, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.lane = lane;
    e.acc  = cyc;
    e.res  = alu_f(s, a, b);
    e.err  = 1'b0;
    e.lat  = ((s == 3'b011 || s == 3'b100) ? SLOW : FAST) + 1;
`ifdef ALU_DIV0_TRAP_EN
    if (s == 3'b100 && b == 0) begin
      e.res = 32'hFFFF_FFFF;
      e.err = 1'b1;
      e.lat = 1;
    end
`endif
    e.zero = (e.res == 0) && !e.err;
    tb_last = lane;
    sb.push_back(e);
  endtask

  task automatic send(input int lane, input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clk); #1;
    set_lane(lane, s, a, b);
    req_valid[lane] = 1'b1;
    @(negedge clk);
    while (!req_ready[lane] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[lane]) begin
      checks++; errors++;
      $display("FAIL send_timeout lane%0d: got req_ready=%b, want bit set", lane, req_ready);
    end else push(lane, s, a, b);
    @(posedge clk); #1;
    req_valid[lane] = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || rsp_valid != 2'b00) && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_idle: got %0d pending, want 0", sb.size());
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    sb.delete();
    in_rsp = 1'b0;
    tb_last = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    set_lane(0, 3'b000, 32'd1, 32'd2);
    set_lane(1, 3'b000, 32'd3, 32'd4);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b, want 00", req_ready); end
    apply_reset();
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_res, rsp_zero, alu_op1, alu_op2, alu_sel} !== '0) begin
      errors++;
      $display("FAIL reset_outs: got rv=%b res=%h z=%b a1=%h a2=%h s=%b, want all 0",
               rsp_valid, rsp_res, rsp_zero, alu_op1, alu_op2, alu_sel);
    end
  endtask

  task automatic test_add();
    send(0, 3'b000, 32'd5, 32'd7);
    @(negedge clk);
    checks++;
    if (alu_op1 !== 32'd5 || alu_op2 !== 32'd7 || alu_sel !== 3'b000) begin
      errors++;
      $display("FAIL add_alu_bus: got %h %h %b, want 5 7 000", alu_op1, alu_op2, alu_sel);
    end
    wait_idle();
  endtask

  task automatic test_rr();
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      logic [1:0] eg;
      @(posedge clk); #1;
      set_lane(0, 3'b000, 32'(r), 32'd100);
      set_lane(1, 3'b001, 32'd200, 32'(r));
      req_valid = 2'b11;
      @(negedge clk);
      eg = (r % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (req_ready !== eg) begin
        errors++;
        $display("FAIL rr_grant round%0d: got %b, want %b", r, req_ready, eg);
      end
      if (req_ready == 2'b01) push(0, 3'b000, 32'(r), 32'd100);
      else if (req_ready == 2'b10) push(1, 3'b001, 32'd200, 32'(r));
      @(posedge clk); #1;
      req_valid = 2'b00;
      wait_idle();
    end
  endtask

  task automatic test_mul();
    send(1, 3'b011, 32'd6, 32'd7);
    for (int k = 0; k < SLOW; k++) begin
      @(negedge clk);
      checks++;
      if (alu_op1 !== 32'd6 || alu_op2 !== 32'd7 || alu_sel !== 3'b011 || rsp_valid !== 2'b00) begin
        errors++;
        $display("FAIL mul_hold cyc%0d: got %h %h %b rv=%b, want 6 7 011 rv=00", k, alu_op1, alu_op2, alu_sel, rsp_valid);
      end
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    int n = 0;
    rsp_ready = 2'b10;
    send(0, 3'b001, 32'd9, 32'd9);
    set_lane(1, 3'b000, 32'd1, 32'd1);
    req_valid[1] = 1'b1;
    @(negedge clk);
    while (rsp_valid == 2'b00 && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b01 || rsp_res !== 32'd0 || rsp_zero !== 1'b1 || req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold cyc%0d: got rv=%b res=%h z=%b rdy=%b, want 01 0 1 00", k, rsp_valid, rsp_res, rsp_zero, req_ready);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_hs_nogrant: got %b, want 00", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL bp_next_grant: got %b, want 10", req_ready);
    end else push(1, 3'b000, 32'd1, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    send(1, 3'b011, 32'd3, 32'd5);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_res, rsp_zero, alu_op1, alu_op2, alu_sel, req_ready} !== '0) begin
      errors++;
      $display("FAIL rstmid_outs: got rv=%b res=%h a1=%h s=%b, want all 0", rsp_valid, rsp_res, alu_op1, alu_sel);
    end
    sb.delete();
    in_rsp = 1'b0;
    tb_last = 1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rstmid_norsp: got response, want none"); end
    @(posedge clk); #1;
    set_lane(0, 3'b101, 32'hF0F0, 32'hFF00);
    set_lane(1, 3'b111, 32'h1, 32'h2);
    req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_first_grant: got %b, want 01", req_ready);
    end else push(0, 3'b101, 32'hF0F0, 32'hFF00);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_idle();
  endtask

  task automatic test_div0();
    logic [2:0] s0;
    s0 = alu_sel;
    send(0, 3'b100, 32'd10, 32'd0);
`ifdef ALU_DIV0_TRAP_EN
    @(negedge clk);
    checks++;
    if (alu_sel !== s0) begin errors++; $display("FAIL div0_alu_untouched: got %b, want %b", alu_sel, s0); end
`else
    @(negedge clk);
    checks++;
    if (alu_sel !== 3'b100 || alu_op1 !== 32'd10 || s0 === 3'b100) begin
      errors++;
      $display("FAIL div0_issued: got sel=%b op1=%h, want 100 0000000a", alu_sel, alu_op1);
    end
`endif
    wait_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      int          ln;
      logic [2:0]  s;
      logic [31:0] a;
      logic [31:0] b;
      ln = int'($urandom_range(1, 0));
      s  = 3'($urandom_range(7, 0));
      a  = $urandom;
      b  = (i == 3) ? 32'd0 : 32'($urandom_range(40, 0));
      send(ln, s, a, b);
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_op1   = '0;
    req_op2   = '0;
    req_sel   = '0;
    rsp_ready = 2'b11;
    test_reset();
    test_add();
    test_rr();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_div0();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
